// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: logical / arithmetic / rotate, left or right, WIDTH a power of two.
// Latency: SHW = $clog2(WIDTH) register stages; one beat per cycle.
// Backpressure: out_valid && !out_ready freezes every stage (bubbles included) and drops in_ready.
module barrel_shift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  // One conditional shift by a fixed power of two. Reserved mode 11 falls
  // through to the logical path; arithmetic left equals logical left.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input int               s,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sgn
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    res  = '0;
    fill = '0;
    if (mode == MODE_ROTATE) begin
      if (dir) res = (d >> s) | (d << (WIDTH - s));
      else     res = (d << s) | (d >> (WIDTH - s));
    end else if (dir) begin
      // Sign comes from the original operand, carried alongside the beat.
      if (mode == MODE_ARITH && sgn) fill = ~({WIDTH{1'b1}} >> s);
      res = (d >> s) | fill;
    end else begin
      res = d << s;
    end
    return res;
  endfunction

  // Stage registers. The full shift amount travels with the beat; stage k
  // only looks at bit k of it.
  logic [SHW-1:0]   vld_q;
  logic [WIDTH-1:0] dat_q  [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [SHW-1:0]   dir_q;
  logic [1:0]       mode_q [SHW];
  logic [SHW-1:0]   sgn_q;
  logic             zero_q;

  // Inputs seen by each stage and the value it will capture.
  logic [SHW-1:0]   src_vld;
  logic [WIDTH-1:0] src_dat  [SHW];
  logic [SHW-1:0]   src_amt  [SHW];
  logic [SHW-1:0]   src_dir;
  logic [1:0]       src_mode [SHW];
  logic [SHW-1:0]   src_sgn;
  logic [WIDTH-1:0] nxt_dat  [SHW];

  logic stall;

  assign out_valid = vld_q[SHW-1];
  assign out_data  = dat_q[SHW-1];
  assign out_zero  = zero_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // Route the input port into stage 0 and each stage into the next, then
  // apply that stage's conditional shift.
  always_comb begin
    src_vld     = '0;
    src_dir     = '0;
    src_sgn     = '0;
    src_vld[0]  = in_valid;
    src_dat[0]  = in_data;
    src_amt[0]  = in_amt;
    src_dir[0]  = in_dir;
    src_mode[0] = in_mode;
    src_sgn[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_dat[k]  = dat_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_dir[k]  = dir_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_sgn[k]  = sgn_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      if (src_amt[k][k])
        nxt_dat[k] = shift_step(src_dat[k], 1 << k, src_dir[k], src_mode[k], src_sgn[k]);
      else
        nxt_dat[k] = src_dat[k];
    end
  end

  // Lock-step pipeline advance; a stall freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      dir_q  <= '0;
      sgn_q  <= '0;
      zero_q <= 1'b0;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k]  <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q  <= src_vld;
      dir_q  <= src_dir;
      sgn_q  <= src_sgn;
      // Zero flag registered with the final stage so it never depends on out_data combinationally.
      zero_q <= src_vld[SHW-1] && (nxt_dat[SHW-1] == '0);
      for (int k = 0; k < SHW; k++) begin
        dat_q[k]  <= nxt_dat[k];
        amt_q[k]  <= src_amt[k];
        mode_q[k] <= src_mode[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: directed mode/latency cases at WIDTH=8 and 16,
// random streams with and without backpressure, and a mid-flight reset.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // WIDTH=8 instance
  logic       iv = 1'b0, ir, idr = 1'b0, ov, ordy = 1'b1, oz;
  logic [7:0] id = '0, od;
  logic [2:0] ia = '0;
  logic [1:0] im = '0;

  // WIDTH=16 instance
  logic        iv16 = 1'b0, ir16, idr16 = 1'b0, ov16, ordy16 = 1'b1, oz16;
  logic [15:0] id16 = '0, od16;
  logic [3:0]  ia16 = '0;
  logic [1:0]  im16 = '0;

  barrel_shift_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .in_data(id), .in_amt(ia), .in_dir(idr), .in_mode(im),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_zero(oz)
  );

  barrel_shift_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16), .in_amt(ia16), .in_dir(idr16), .in_mode(im16),
    .out_valid(ov16), .out_ready(ordy16), .out_data(od16), .out_zero(oz16)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: shifts expressed as multiply/divide by 2^a modulo 2^w.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic dr,
                                            input logic [1:0] m, input int w);
    longint unsigned span, x, p, r;
    longint          sx;
    span = 64'd1 << w;
    x    = 64'(d) % span;
    p    = 64'd1 << a;
    if (m == 2'b10) begin
      if (dr) r = x / p + (x % p) * (span / p);
      else    r = (x * p) % span + x / (span / p);
    end else if (dr && m == 2'b01) begin
      sx = (x >= span / 2) ? longint'(x) - longint'(span) : longint'(x);
      sx = (sx >= 0) ? sx / longint'(p) : -((-sx + longint'(p) - 1) / longint'(p));
      r  = (sx < 0) ? longint'(sx + longint'(span)) : sx;
    end else if (dr) begin
      r = x / p;
    end else begin
      r = (x * p) % span;
    end
    return r[31:0];
  endfunction

  // Scoreboard for the WIDTH=8 instance.
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic [7:0] prev_od    = '0;
  bit         prev_stall = 1'b0;
  bit         mon_en     = 1'b0;
  int         n_out      = 0;

  // Output-side monitor: handshake law, stall hold, in-order data and zero flag.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("in_ready_law", 32'(ir), 32'(!(ov && !ordy)));
      if (prev_stall) begin
        check("hold_valid", 32'(ov), 32'd1);
        check("hold_data", 32'(od), 32'(prev_od));
      end
      if (ov && ordy) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(od), 32'(mon_e));
          check("out_zero", 32'(oz), 32'(mon_e == 8'h00));
        end
      end
      prev_stall = ov && !ordy;
      prev_od    = od;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present one beat; returns one time step after its accept edge.
  task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] m);
    int          t;
    logic [31:0] r32;
    id = d; ia = a; idr = dr; im = m; iv = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ir && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir) check("accept_timeout", 32'd0, 32'd1);
    r32 = ref_shift(32'(d), int'(a), dr, m, 8);
    exp_q.push_back(r32[7:0]);
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  // Single directed beat at WIDTH=8 with exact latency check against a fixed expectation.
  task automatic dir8(input string tag, input logic [7:0] d, input logic [2:0] a, input logic dr,
                      input logic [1:0] m, input logic [7:0] expv);
    ordy = 1'b1;
    send8(d, a, dr, m);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({tag, "_early"}, 32'(ov), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(ov), 32'd1);
    check({tag, "_data"}, 32'(od), 32'(expv));
    check({tag, "_zero"}, 32'(oz), 32'(expv == 8'h00));
    @(posedge clk);
    #1;
  endtask

  // Single directed beat at WIDTH=16 against the reference, latency 4.
  task automatic dir16(input string tag, input logic [15:0] d, input logic [3:0] a, input logic dr,
                       input logic [1:0] m);
    logic [31:0] r32;
    r32 = ref_shift(32'(d), int'(a), dr, m, 16);
    id16 = d; ia16 = a; idr16 = dr; im16 = m; iv16 = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(ir16), 32'd1);
    @(posedge clk);
    #1 iv16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_early"}, 32'(ov16), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(ov16), 32'd1);
    check({tag, "_data"}, 32'(od16), 32'(r32[15:0]));
    check({tag, "_zero"}, 32'(oz16), 32'(r32[15:0] == 16'h0000));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int  t;
    int  out_base;
    bit  done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_out_data", 32'(od), 32'd0);
    check("rst_out_zero", 32'(oz), 32'd0);
    check("rst_in_ready", 32'(ir), 32'd1);
    check("rst_out_valid16", 32'(ov16), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Mode sweep at WIDTH=8
    dir8("ll3", 8'hB1, 3'd3, 1'b0, 2'b00, 8'h88);
    dir8("lr3", 8'hB1, 3'd3, 1'b1, 2'b00, 8'h16);
    dir8("ar3", 8'hB1, 3'd3, 1'b1, 2'b01, 8'hF6);
    dir8("rr3", 8'hB1, 3'd3, 1'b1, 2'b10, 8'h36);
    dir8("rl3", 8'hB1, 3'd3, 1'b0, 2'b10, 8'h8D);

    // Zero flag, amount 0, reserved mode
    dir8("zero_ll1", 8'h80, 3'd1, 1'b0, 2'b00, 8'h00);
    dir8("lr7", 8'h80, 3'd7, 1'b1, 2'b00, 8'h01);
    for (int m = 0; m < 4; m++) dir8("amt0", 8'h5A, 3'd0, 1'(m & 1), 2'(m), 8'h5A);
    dir8("rsvd_r2", 8'hF0, 3'd2, 1'b1, 2'b11, 8'h3C);

    // Back-to-back stream of 16 random beats
    ordy = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
      end
      begin
        t = 0;
        @(negedge clk);
        while (!ov && t < 40) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 16; i++) begin
          check("stream_consecutive", 32'(ov), 32'd1);
          @(negedge clk);
        end
        check("stream_end", 32'(ov), 32'd0);
      end
    join
    wait_drain("stream_drain");

    // Random backpressure stream
    out_base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int r;
          r = $urandom_range(0, 2);
          if (r != 0) begin
            repeat (r) @(posedge clk);
            #1;
          end
          send8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ordy = 1'($urandom);
        end
        ordy = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_beat_count", 32'(n_out - out_base), 32'd40);

    // Reset with three beats in flight and a fourth presented on the reset edge
    mon_en = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      id = 8'($urandom) | 8'h01; ia = 3'($urandom_range(0, 7)); idr = 1'($urandom); im = 2'($urandom);
      iv = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    id = 8'h77; ia = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    iv  = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(ov), 32'd0);
    check("mid_rst_out_data", 32'(od), 32'd0);
    check("mid_rst_out_zero", 32'(oz), 32'd0);
    check("mid_rst_in_ready", 32'(ir), 32'd1);
    exp_q.delete();
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_ghost", 32'(ov), 32'd0);
    @(posedge clk);
    #1;
    dir8("post_rst", 8'hB1, 3'd3, 1'b1, 2'b10, 8'h36);

    // WIDTH=16 mode sweep, amount 9, latency 4
    dir16("w16_ll", 16'hB1C3, 4'd9, 1'b0, 2'b00);
    dir16("w16_lr", 16'hB1C3, 4'd9, 1'b1, 2'b00);
    dir16("w16_ar", 16'hB1C3, 4'd9, 1'b1, 2'b01);
    dir16("w16_rr", 16'hB1C3, 4'd9, 1'b1, 2'b10);
    dir16("w16_rl", 16'hB1C3, 4'd9, 1'b0, 2'b10);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
